// File: rtl/nn_pkg.sv
// Shared definitions for the NN sliding-window block: controller state
// encoding, default pixel width and the (row, col) window packing rule.
package nn_pkg;

  localparam int NN_PIX_W = 8;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    STEP = 2'd1,
    HOLD = 2'd2
  } nn_state_t;

  // Bit offset of pixel (r, c) inside a packed ROW x COLS window.
  function automatic int nn_pix_lsb(input int r, input int c, input int cols, input int w);
    return (r * cols + c) * w;
  endfunction

endpackage

// File: rtl/nn_sld_win_ctrl.sv
// Sliding-window controller: configuration latch, FILL/STEP/HOLD state
// machine, fill and stride counters, input handshake and window-valid flag.
module nn_sld_win_ctrl
  import nn_pkg::*;
#(
  parameter int COL_NUM  = 6,
  parameter int STRIDE_W = 3
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_clr,
  input  logic                i_split,
  input  logic                i_half,
  input  logic [STRIDE_W-1:0] i_stride,
  input  logic                i_valid,
  input  logic                i_win_rdy,
  output logic                o_ready,
  output logic                o_win_vld,
  output logic                o_shift,
  output logic                o_split,
  output logic                o_half
);

  localparam int CW = $clog2(COL_NUM + 1);
  localparam logic [CW-1:0]     SW_FULL = CW'(COL_NUM);
  localparam logic [CW-1:0]     SW_HALF = CW'(COL_NUM / 2);
  localparam logic [CW-1:0]     FILL_ONE = CW'(1);
  localparam logic [STRIDE_W:0] STRD_ONE = (STRIDE_W + 1)'(1);

  nn_state_t             state_q, state_d;
  logic [CW-1:0]         fill_q, fill_d;
  logic [STRIDE_W-1:0]   strd_q, strd_d;
  logic                  split_q, half_q;
  logic [STRIDE_W-1:0]   stride_q;
  logic [CW-1:0]         sw;
  logic [CW-1:0]         fill_inc;
  logic [STRIDE_W:0]     eff_stride;
  logic [STRIDE_W:0]     strd_inc;
  logic                  accept;

  assign sw         = split_q ? SW_HALF : SW_FULL;
  assign eff_stride = (stride_q == '0) ? STRD_ONE : {1'b0, stride_q};
  assign fill_inc   = fill_q + FILL_ONE;
  assign strd_inc   = {1'b0, strd_q} + STRD_ONE;

  assign o_ready   = (state_q != HOLD) && !i_clr;
  assign accept    = i_valid && o_ready;
  assign o_shift   = accept;
  assign o_win_vld = (state_q == HOLD);
  assign o_split   = split_q;
  assign o_half    = half_q;

  // Configuration is captured only on a sweep restart.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      split_q  <= 1'b0;
      half_q   <= 1'b0;
      stride_q <= STRIDE_W'(1);
    end else if (i_clr) begin
      split_q  <= i_split;
      half_q   <= i_half;
      stride_q <= i_stride;
    end
  end

  // State and counter registers.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= FILL;
      fill_q  <= '0;
      strd_q  <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      strd_q  <= strd_d;
    end
  end

  // Next-state logic; a restart overrides every other transition.
  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    strd_d  = strd_q;
    if (i_clr) begin
      state_d = FILL;
      fill_d  = '0;
      strd_d  = '0;
    end else begin
      case (state_q)
        FILL: begin
          if (accept) begin
            fill_d = fill_inc;
            if (fill_inc == sw) begin
              state_d = HOLD;
              strd_d  = '0;
            end
          end
        end
        HOLD: begin
          if (i_win_rdy) state_d = STEP;
        end
        STEP: begin
          if (accept) begin
            if (strd_inc == eff_stride) begin
              state_d = HOLD;
              strd_d  = '0;
            end else begin
              strd_d = strd_inc[STRIDE_W-1:0];
            end
          end
        end
        default: begin
          state_d = FILL;
        end
      endcase
    end
  end

endmodule

// File: rtl/nn_sld_win.sv
// Sliding-window register file feeding the NN PE array. Columns shift into
// the active segment (full width or one half) on every accepted transfer.
// Optional build macro NN_SLD_ZPAD_EN adds i_pad, which shifts in a zero
// column instead of i_data (left/right zero padding).
module nn_sld_win
  import nn_pkg::*;
#(
  parameter int DATA_WIDTH = NN_PIX_W,
  parameter int ROW_NUM    = 6,
  parameter int COL_NUM    = 6,
  parameter int STRIDE_W   = 3
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst,
  input  logic                                  i_clr,
  input  logic                                  i_split,
  input  logic                                  i_half,
  input  logic [STRIDE_W-1:0]                   i_stride,
`ifdef NN_SLD_ZPAD_EN
  input  logic                                  i_pad,
`endif
  input  logic [DATA_WIDTH*ROW_NUM-1:0]         i_data,
  input  logic                                  i_valid,
  output logic                                  o_ready,
  output logic [DATA_WIDTH*ROW_NUM*COL_NUM-1:0] o_img,
  output logic                                  o_win_vld,
  input  logic                                  i_win_rdy
);

  localparam int HW = COL_NUM / 2;

  typedef logic [ROW_NUM-1:0][DATA_WIDTH-1:0] col_t;

  logic         shift;
  logic         split;
  logic         half;
  col_t         col_in;
  col_t         img_q [COL_NUM];
  col_t         src   [COL_NUM];
  logic [COL_NUM-1:0] seg_en;

  nn_sld_win_ctrl #(
    .COL_NUM  (COL_NUM),
    .STRIDE_W (STRIDE_W)
  ) u_ctrl (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clr     (i_clr),
    .i_split   (i_split),
    .i_half    (i_half),
    .i_stride  (i_stride),
    .i_valid   (i_valid),
    .i_win_rdy (i_win_rdy),
    .o_ready   (o_ready),
    .o_win_vld (o_win_vld),
    .o_shift   (shift),
    .o_split   (split),
    .o_half    (half)
  );

`ifdef NN_SLD_ZPAD_EN
  assign col_in = i_pad ? '0 : col_t'(i_data);
`else
  assign col_in = col_t'(i_data);
`endif

  // Per-column segment membership and shift source: the segment base takes
  // the new column, every other member takes its lower neighbour.
  always_comb begin
    for (int c = 0; c < COL_NUM; c++) begin
      seg_en[c] = !split || (half ? (c >= HW) : (c < HW));
    end
    src[0] = col_in;
    for (int c = 1; c < COL_NUM; c++) begin
      src[c] = (split && half && (c == HW)) ? col_in : img_q[c-1];
    end
  end

  // Window shift register; columns outside the segment hold.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int c = 0; c < COL_NUM; c++) img_q[c] <= '0;
    end else if (shift) begin
      for (int c = 0; c < COL_NUM; c++) begin
        if (seg_en[c]) img_q[c] <= src[c];
      end
    end
  end

  for (genvar r = 0; r < ROW_NUM; r++) begin : g_row
    for (genvar c = 0; c < COL_NUM; c++) begin : g_col
      assign o_img[nn_pix_lsb(r, c, COL_NUM, DATA_WIDTH) +: DATA_WIDTH] = img_q[c][r];
    end
  end

endmodule

// File: tb/tb_nn_sld_win.sv
// Self-checking bench for nn_sld_win: directed scenarios plus randomized
// traffic against a column-array reference model.
module tb_nn_sld_win;

  localparam int DW   = 8;
  localparam int RN   = 6;
  localparam int CN   = 6;
  localparam int SWD  = 3;
  localparam int IMGW = DW * RN * CN;

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic              i_clr;
  logic              i_split;
  logic              i_half;
  logic [SWD-1:0]    i_stride;
  logic [DW*RN-1:0]  i_data;
  logic              i_valid;
  logic              o_ready;
  logic [IMGW-1:0]   o_img;
  logic              o_win_vld;
  logic              i_win_rdy;
`ifdef NN_SLD_ZPAD_EN
  logic              i_pad;
`endif
  logic              cur_pad;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state
  logic [DW-1:0] mimg [CN][RN];
  int m_split, m_half, m_stride;
  int m_phase;   // 0 filling, 1 stepping, 2 window held
  int m_fill, m_strd;

  nn_sld_win #(
    .DATA_WIDTH (DW),
    .ROW_NUM    (RN),
    .COL_NUM    (CN),
    .STRIDE_W   (SWD)
  ) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clr     (i_clr),
    .i_split   (i_split),
    .i_half    (i_half),
    .i_stride  (i_stride),
`ifdef NN_SLD_ZPAD_EN
    .i_pad     (i_pad),
`endif
    .i_data    (i_data),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .o_img     (o_img),
    .o_win_vld (o_win_vld),
    .i_win_rdy (i_win_rdy)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [IMGW-1:0] got, input logic [IMGW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [DW*RN-1:0] colval(input int n);
    logic [DW*RN-1:0] v;
    for (int r = 0; r < RN; r++) v[r*DW +: DW] = DW'(16 * n + r);
    return v;
  endfunction

  function automatic logic [DW-1:0] pix(input int r, input int c);
    return o_img[(r*CN + c)*DW +: DW];
  endfunction

  function automatic logic [IMGW-1:0] model_img();
    logic [IMGW-1:0] v;
    for (int r = 0; r < RN; r++)
      for (int c = 0; c < CN; c++)
        v[(r*CN + c)*DW +: DW] = mimg[c][r];
    return v;
  endfunction

  task automatic m_reset();
    for (int c = 0; c < CN; c++)
      for (int r = 0; r < RN; r++) mimg[c][r] = '0;
    m_split = 0; m_half = 0; m_stride = 1;
    m_phase = 0; m_fill = 0; m_strd = 0;
  endtask

  // Apply one clock edge of the window rules to the model.
  task automatic model_step();
    int sw, base, eff;
    if (i_clr) begin
      m_split = int'(i_split); m_half = int'(i_half); m_stride = int'(i_stride);
      m_phase = 0; m_fill = 0; m_strd = 0;
    end else if (m_phase == 2) begin
      if (i_win_rdy) m_phase = 1;
    end else if (i_valid) begin
      sw   = m_split ? CN / 2 : CN;
      base = (m_split && m_half) ? CN / 2 : 0;
      eff  = (m_stride == 0) ? 1 : m_stride;
      for (int k = sw - 1; k >= 1; k--) mimg[base+k] = mimg[base+k-1];
      for (int r = 0; r < RN; r++) mimg[base][r] = cur_pad ? '0 : i_data[r*DW +: DW];
      if (m_phase == 0) begin
        m_fill++;
        if (m_fill == sw) begin m_phase = 2; m_strd = 0; end
      end else begin
        m_strd++;
        if (m_strd == eff) begin m_phase = 2; m_strd = 0; end
      end
    end
  endtask

  task automatic compare_all();
    chk("ready", IMGW'(o_ready), IMGW'((m_phase != 2) && !i_clr));
    chk("win_vld", IMGW'(o_win_vld), IMGW'(m_phase == 2));
    chk("img", o_img, model_img());
  endtask

  task automatic step();
    @(posedge i_clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic drive(input logic clr, input logic sp, input logic hf, input logic [SWD-1:0] st,
                       input logic vl, input logic [DW*RN-1:0] d, input logic wr, input logic pd);
    i_clr = clr; i_split = sp; i_half = hf; i_stride = st;
    i_valid = vl; i_data = d; i_win_rdy = wr; cur_pad = pd;
`ifdef NN_SLD_ZPAD_EN
    i_pad = pd;
`endif
    step();
  endtask

  task automatic cfg(input logic sp, input logic hf, input logic [SWD-1:0] st);
    drive(1'b1, sp, hf, st, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic push(input int n);
    drive(1'b0, 1'b0, 1'b0, '0, 1'b1, colval(n), 1'b0, 1'b0);
  endtask

  task automatic ack();
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    logic [63:0] rnd;
    i_rst = 1'b0; i_clr = 1'b0; i_split = 1'b0; i_half = 1'b0; i_stride = '0;
    i_data = '0; i_valid = 1'b0; i_win_rdy = 1'b0; cur_pad = 1'b0;
`ifdef NN_SLD_ZPAD_EN
    i_pad = 1'b0;
`endif
    m_reset();
    #12;
    chk("rst_img", o_img, '0);
    chk("rst_vld", IMGW'(o_win_vld), '0);
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    compare_all();

`ifdef NN_SLD_ZPAD_EN
    // Zero-padding column counts toward the window
    cfg(1'b0, 1'b0, 3'd1);
    for (int n = 1; n <= 5; n++) push(n);
    drive(1'b0, 1'b0, 1'b0, '0, 1'b1, colval(6), 1'b0, 1'b1);
    chk("pad_vld", IMGW'(o_win_vld), IMGW'(1));
    chk("pad_c0", IMGW'(pix(2, 0)), '0);
    chk("pad_c1", IMGW'(pix(2, 1)), IMGW'(8'h52));
`endif

    // Full width, stride 1
    cfg(1'b0, 1'b0, 3'd1);
    for (int n = 1; n <= 6; n++) push(n);
    chk("t1_vld", IMGW'(o_win_vld), IMGW'(1));
    chk("t1_c0", IMGW'(pix(0, 0)), IMGW'(8'h60));
    chk("t1_c5", IMGW'(pix(3, 5)), IMGW'(8'h13));
    push(7);
    chk("t1_ready_hold", IMGW'(o_ready), '0);

    // Full width, stride 2, valid held through HOLD
    cfg(1'b0, 1'b0, 3'd2);
    for (int n = 1; n <= 6; n++) push(n);
    push(7);
    push(7);
    drive(1'b0, 1'b0, 1'b0, '0, 1'b1, colval(7), 1'b1, 1'b0);
    push(7);
    chk("t2_mid_vld", IMGW'(o_win_vld), '0);
    push(8);
    chk("t2_vld", IMGW'(o_win_vld), IMGW'(1));
    chk("t2_c0", IMGW'(pix(0, 0)), IMGW'(8'h80));
    chk("t2_c1", IMGW'(pix(1, 1)), IMGW'(8'h71));
    chk("t2_c2", IMGW'(pix(0, 2)), IMGW'(8'h60));

    // Split, high half, over an 0xAA preload
    cfg(1'b0, 1'b0, 3'd1);
    for (int n = 0; n < 6; n++)
      drive(1'b0, 1'b0, 1'b0, '0, 1'b1, {(DW*RN/8){8'hAA}}, 1'b0, 1'b0);
    cfg(1'b1, 1'b1, 3'd1);
    for (int n = 1; n <= 3; n++) push(n);
    chk("t3_vld", IMGW'(o_win_vld), IMGW'(1));
    chk("t3_c3", IMGW'(pix(0, 3)), IMGW'(8'h30));
    chk("t3_c5", IMGW'(pix(5, 5)), IMGW'(8'h15));
    chk("t3_c0", IMGW'(pix(4, 0)), IMGW'(8'hAA));
    chk("t3_c2", IMGW'(pix(0, 2)), IMGW'(8'hAA));

    // Split, low half, stride 0 acts as 1
    cfg(1'b1, 1'b0, 3'd0);
    for (int n = 10; n <= 12; n++) push(n - 8);
    for (int i = 0; i < 3; i++) begin
      ack();
      push(5 + i);
      chk("t4_vld", IMGW'(o_win_vld), IMGW'(1));
      chk("t4_hi", IMGW'(pix(0, 3)), IMGW'(8'h30));
    end

    // Restart while holding, with valid and ack in the same cycle
    drive(1'b1, 1'b0, 1'b0, 3'd1, 1'b1, colval(9), 1'b1, 1'b0);
    chk("t5_vld", IMGW'(o_win_vld), '0);
    chk("t5_c0", IMGW'(pix(0, 0)), IMGW'(8'h70));
    for (int n = 1; n <= 5; n++) push(n);
    chk("t5_refill", IMGW'(o_win_vld), '0);
    push(6);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rnd = {$urandom(), $urandom()};
      drive(($urandom % 30) == 0, 1'($urandom), 1'($urandom), SWD'($urandom),
            ($urandom % 4) != 0, rnd[DW*RN-1:0], ($urandom % 3) == 0,
`ifdef NN_SLD_ZPAD_EN
            ($urandom % 6) == 0
`else
            1'b0
`endif
            );
    end

    // Asynchronous reset mid-STEP
    cfg(1'b0, 1'b0, 3'd3);
    for (int n = 1; n <= 6; n++) push(n);
    ack();
    push(7);
    chk("t6_nonzero", IMGW'(o_img != '0), IMGW'(1));
    #3 i_rst = 1'b0;
    #1;
    chk("t6_img", o_img, '0);
    chk("t6_vld", IMGW'(o_win_vld), '0);
    m_reset();
    #1 i_rst = 1'b1;
    push(1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/nn_sld_win.md
Name: nn_sld_win

Overview:
- Parametrised sliding-window register file feeding the NN PE array.
- Accepts one image column (ROW_NUM pixels) per valid/ready transfer and shifts it into a ROW_NUM x COL_NUM window.
- Two window configurations: full-width, or split into two independent half-width segments.
- Signals when a complete window is available, honouring a configurable horizontal stride, and stalls input until the consumer acknowledges the window.

Parameters:
- DATA_WIDTH, 8, pixel width in bits.
- ROW_NUM, 6, window rows.
- COL_NUM, 6, window columns; must be even and >= 2.
- STRIDE_W, 3, width of the stride field.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous, active-low reset.
- i_clr  in  1  synchronous sweep restart; latches configuration and clears counters.
- i_split  in  1  configuration: 0 = full width, 1 = two halves of COL_NUM/2; sampled on i_clr.
- i_half  in  1  configuration, split mode only: 0 = low half (cols 0..COL_NUM/2-1), 1 = high half; sampled on i_clr.
- i_stride  in  STRIDE_W  columns per window step; 0 is treated as 1; sampled on i_clr.
- i_data  in  DATA_WIDTH*ROW_NUM  column data; row r at [r*DATA_WIDTH +: DATA_WIDTH].
- i_valid  in  1  column valid.
- o_ready  out  1  column accepted when i_valid && o_ready.
- o_img  out  DATA_WIDTH*ROW_NUM*COL_NUM  window; pixel (r,c) at [(r*COL_NUM+c)*DATA_WIDTH +: DATA_WIDTH].
- o_win_vld  out  1  window complete.
- i_win_rdy  in  1  consumer acknowledge.

Behaviour:
- Reset: o_img=0, o_win_vld=0, state=FILL, fill_cnt=0, stride_cnt=0, latched config = {split=0, half=0, stride=1}.
- Active segment:
  - split=0: base=0, SW=COL_NUM.
  - split=1: SW=COL_NUM/2; base = 0 (half=0) or COL_NUM/2 (half=1).
- Accepted column, per row r:
  - col base <= i_data row r.
  - col base+k <= col base+k-1, for k=1..SW-1; the oldest column is discarded.
  - All columns outside the segment hold.
- No accept: o_img holds.
- o_ready = (state != HOLD) && !i_clr.
- i_clr has priority: counters cleared, config latched, state=FILL, o_win_vld=0; o_img unchanged; a same-cycle column is not accepted.
- FILL:
  - Each accept increments fill_cnt.
  - The accept that makes fill_cnt == SW moves to HOLD, sets o_win_vld the next cycle, and sets stride_cnt=0.
- HOLD:
  - o_win_vld=1, no column accepted.
  - i_win_rdy moves to STEP and o_win_vld=0 the next cycle.
  - If i_win_rdy and i_clr coincide, clr wins.
- STEP:
  - Each accept increments stride_cnt.
  - When stride_cnt+1 == effective stride: move to HOLD and set stride_cnt=0.
  - Stride > SW is legal; some columns are skipped entirely.
- Latency: column accepted on edge t → o_img and o_win_vld updated after edge t; window visible from cycle t+1.
- Counters are sized ceil(log2(COL_NUM+1)) and STRIDE_W; no wrap is possible because fill_cnt stops at SW.

Optional Feature:
- Macro: NN_SLD_ZPAD_EN.
- Defined: adds input port i_pad (1 bit). An accepted column with i_pad=1 shifts in all zeros instead of i_data. Counters advance identically. Used for left/right zero padding.
- Undefined: no i_pad port; i_data is always shifted in.

Decomposition:
- Shared package nn_pkg:
  - state encoding: FILL=2'd0, STEP=2'd1, HOLD=2'd2.
  - pixel-width constant and the index-function convention for (r,c) packing.
- One natural sub-module, nn_sld_win_ctrl: state machine, fill/stride counters, config latch, o_ready / o_win_vld.
- Datapath shift array stays in nn_sld_win.

Test Plan:
- Reset, then full mode (split=0, stride=1); stream columns 1..6 with row r value = 16*col+r.
  - o_win_vld rises the cycle after column 6.
  - o_img col0 = column 6, col5 = column 1.
  - o_ready=0 until acknowledged.
- Full mode, stride=2: after the first window and ack, the next window fires after 2 more accepts.
  - col0 = column 8, col1 = column 7.
  - i_valid held high during HOLD: no column lost, none duplicated.
- Split, half=1: preload all 36 pixels with 0xAA via full mode; clr with split=1, half=1; push columns 1..3.
  - Window fires after 3.
  - cols 3..5 = 3,2,1; cols 0..2 remain 0xAA.
- Split, half=0, stride=0 (treated as 1): after the first window, each accept plus ack yields a window.
  - High half unchanged throughout.
- i_clr asserted in HOLD together with i_valid and i_win_rdy: o_win_vld=0 next cycle, column not accepted, o_img unchanged, fill restarts from 0.
- i_rst pulled low mid-STEP with o_img nonzero: o_img=0 and o_win_vld=0 immediately, asynchronously. With NN_SLD_ZPAD_EN, a column with i_pad=1 loads zeros and counts toward the window.
